// File: rtl/rv_fetch_unit_if.sv
// Fetch-unit bundle: ROM port, issue handshake, redirect/resume controls and status.
// master is the fetch unit, slave is the core/ROM side.
interface rv_fetch_unit_if #(
  parameter int unsigned PC_W    = 11,
  parameter int unsigned IMEM_AW = 8,
  parameter int unsigned CNT_W   = 32
) ();
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_out;
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               resume;
  logic               halt;
  logic               trap_misalign;
  logic [CNT_W-1:0]   retired_cnt;

  modport master (
    output imem_addr, instr, instr_valid, pc_out, halt, trap_misalign, retired_cnt,
    input  imem_rdata, stall, redirect, redirect_pc, resume
  );

  modport slave (
    input  imem_addr, instr, instr_valid, pc_out, halt, trap_misalign, retired_cnt,
    output imem_rdata, stall, redirect, redirect_pc, resume
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// RV32I fetch / next-PC sequencer: owns the PC, reads a 1-cycle-latency ROM and issues each
// instruction through a valid/stall handshake with redirect, halt-on-fault and resume.
module rv_fetch_unit #(
  parameter int unsigned     PC_W         = 11,
  parameter int unsigned     IMEM_AW      = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned     CNT_W        = 32
) (
  input logic             clk,
  input logic             rst,
  rv_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StFetch, StLoad, StIssue, StHalt} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  function automatic logic opcode_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  assign accept = (state_q == StIssue) && !bus.stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    trap_d  = trap_q;
    cnt_d   = cnt_q;
    case (state_q)
      StFetch: state_d = StLoad;
      StLoad: begin
        instr_d = bus.imem_rdata;
        state_d = opcode_legal(bus.imem_rdata[6:0]) ? StIssue : StHalt;
      end
      StIssue: begin
        if (accept) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bus.redirect) begin
            // A misaligned target is still latched so pc_out reports it while halted.
            pc_d = bus.redirect_pc;
            if (bus.redirect_pc[1:0] != 2'b00) begin
              trap_d  = 1'b1;
              state_d = StHalt;
            end else begin
              state_d = StFetch;
            end
          end else begin
            pc_d    = pc_q + PC_W'(4);
            state_d = StFetch;
          end
        end
      end
      StHalt: begin
        if (bus.resume) begin
          pc_d    = RESET_VECTOR;
          trap_d  = 1'b0;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr     = pc_q[IMEM_AW+1:2];
  assign bus.instr         = instr_q;
  assign bus.instr_valid   = (state_q == StIssue);
  assign bus.pc_out        = pc_q;
  assign bus.halt          = (state_q == StHalt);
  assign bus.trap_misalign = trap_q;
  assign bus.retired_cnt   = cnt_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed sequences, an opcode/redirect vector table and a
// randomized run against a transaction-level reference model; a second PC_W=6 instance.
module tb_rv_fetch_unit;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst6 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_fetch_unit_if #(.PC_W(11), .IMEM_AW(8), .CNT_W(32)) bus  ();
  rv_fetch_unit_if #(.PC_W(6),  .IMEM_AW(4), .CNT_W(4))  bus6 ();

  rv_fetch_unit #(.PC_W(11), .IMEM_AW(8), .RESET_VECTOR(11'h000), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rv_fetch_unit #(.PC_W(6), .IMEM_AW(4), .RESET_VECTOR(6'h00), .CNT_W(4)) dut6 (
    .clk (clk),
    .rst (rst6),
    .bus (bus6)
  );

  logic [31:0] rom  [256];
  logic [31:0] rom6 [16];

  always_ff @(posedge clk) bus.imem_rdata  <= rom[bus.imem_addr];
  always_ff @(posedge clk) bus6.imem_rdata <= rom6[bus6.imem_addr];

  logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // addi with the word index in the upper bits so every slot is distinguishable
  function automatic logic [31:0] addi_word(input int i);
    return (32'(i) << 20) | 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall        = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.resume       = 1'b0;
    bus6.stall       = 1'b0;
    bus6.redirect    = 1'b0;
    bus6.redirect_pc = '0;
    bus6.resume      = 1'b0;
  endtask

  // Reset released 1 time unit after a rising edge; state is then FETCH.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic        redir;
    logic [10:0] rpc;
    logic        exp_valid;
    logic        exp_halt;
    logic        exp_trap;
    logic [10:0] exp_pc;
  } vec_t;

  vec_t vecs [14];

  // Reference model state
  logic [10:0] m_pc;
  int          m_wait;
  bit          m_halt;
  bit          m_trap;
  logic [31:0] m_cnt;

  initial begin
    vecs[0]  = '{32'h00A0_0033, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h004};
    vecs[1]  = '{32'h0010_0013, 1'b1, 11'h100, 1'b1, 1'b0, 1'b0, 11'h100};
    vecs[2]  = '{32'h0020_0023, 1'b1, 11'h101, 1'b1, 1'b1, 1'b1, 11'h101};
    vecs[3]  = '{32'h0030_0003, 1'b1, 11'h7FE, 1'b1, 1'b1, 1'b1, 11'h7FE};
    vecs[4]  = '{32'h0040_0063, 1'b1, 11'h7FC, 1'b1, 1'b0, 1'b0, 11'h7FC};
    vecs[5]  = '{32'h0050_006F, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h004};
    vecs[6]  = '{32'h0060_0067, 1'b1, 11'h003, 1'b1, 1'b1, 1'b1, 11'h003};
    vecs[7]  = '{32'h0070_0037, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h004};
    vecs[8]  = '{32'h0080_0017, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h004};
    vecs[9]  = '{32'h0000_007F, 1'b1, 11'h040, 1'b0, 1'b1, 1'b0, 11'h000};
    vecs[10] = '{32'h0000_0000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000};
    vecs[11] = '{32'h0000_0073, 1'b1, 11'h002, 1'b0, 1'b1, 1'b0, 11'h000};
    vecs[12] = '{32'h0000_000F, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000};
    vecs[13] = '{32'h0000_0053, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h000};

    idle_inputs();
    for (int i = 0; i < 256; i++) rom[i] = addi_word(i);
    for (int i = 0; i < 16; i++) rom6[i] = addi_word(i);
    rom[3] = 32'h0000_007F;

    // Reset values while reset is held
    #2;
    rst  = 1'b1;
    rst6 = 1'b1;
    #1;
    check("rst_valid", bus.instr_valid, 0);
    check("rst_pc", bus.pc_out, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_halt", bus.halt, 0);
    check("rst_trap", bus.trap_misalign, 0);
    check("rst_cnt", bus.retired_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Straight-line issue of 0,4,8 then illegal word at 0xC
    tick(1); check("t1_lat_c1", bus.instr_valid, 0);
    tick(1); check("t1_valid0", bus.instr_valid, 1);
    check("t1_pc0", bus.pc_out, 11'h000);
    check("t1_instr0", bus.instr, addi_word(0));
    tick(1); check("t1_gap", bus.instr_valid, 0);
    check("t1_cnt1", bus.retired_cnt, 1);
    tick(2); check("t1_valid4", bus.instr_valid, 1);
    check("t1_pc4", bus.pc_out, 11'h004);
    tick(3); check("t1_valid8", bus.instr_valid, 1);
    check("t1_pc8", bus.pc_out, 11'h008);
    tick(1); check("t1_cnt3", bus.retired_cnt, 3);
    tick(1); check("t5_noval_load", bus.instr_valid, 0);
    tick(1); check("t5_halt", bus.halt, 1);
    check("t5_trap", bus.trap_misalign, 0);
    check("t5_pc", bus.pc_out, 11'h00C);
    check("t5_valid", bus.instr_valid, 0);
    check("t5_cnt", bus.retired_cnt, 3);
    tick(2); check("t5_still_halt", bus.halt, 1);

    // Resume, then stall 5 cycles in ISSUE at pc 4
    bus.resume = 1'b1;
    tick(1); check("t2_unhalt", bus.halt, 0);
    check("t2_pc_rv", bus.pc_out, 11'h000);
    bus.resume = 1'b0;
    tick(2); check("t2_pc0", bus.pc_out, 11'h000);
    check("t2_valid0", bus.instr_valid, 1);
    tick(1);
    bus.stall = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", bus.instr_valid, 1);
      check("t2_stall_pc", bus.pc_out, 11'h004);
      check("t2_stall_instr", bus.instr, addi_word(1));
      check("t2_stall_addr", bus.imem_addr, 8'd1);
      check("t2_stall_cnt", bus.retired_cnt, 4);
      tick(1);
    end
    bus.stall = 1'b0;
    tick(1); check("t2_cnt5", bus.retired_cnt, 5);
    tick(2); check("t2_pc8", bus.pc_out, 11'h008);
    check("t2_valid8", bus.instr_valid, 1);

    // Redirect to 0x40 held while stalled, taken on accept
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 11'h040;
    tick(2); check("t3_stalled_pc", bus.pc_out, 11'h008);
    check("t3_stalled_valid", bus.instr_valid, 1);
    bus.stall = 1'b0;
    tick(1); check("t3_redir_pc", bus.pc_out, 11'h040);
    check("t3_cnt", bus.retired_cnt, 6);
    bus.redirect = 1'b0;
    tick(2); check("t3_valid40", bus.instr_valid, 1);
    check("t3_instr40", bus.instr, addi_word(16));

    // Misaligned redirect halts; redirect ignored in HALT; resume restarts at 0
    bus.redirect    = 1'b1;
    bus.redirect_pc = 11'h042;
    tick(1); check("t4_halt", bus.halt, 1);
    check("t4_trap", bus.trap_misalign, 1);
    check("t4_pc", bus.pc_out, 11'h042);
    check("t4_valid", bus.instr_valid, 0);
    bus.redirect_pc = 11'h080;
    tick(2); check("t4_frozen_pc", bus.pc_out, 11'h042);
    bus.redirect = 1'b0;
    bus.resume   = 1'b1;
    tick(1); check("t4_resume_halt", bus.halt, 0);
    check("t4_resume_trap", bus.trap_misalign, 0);
    bus.resume = 1'b0;
    tick(2); check("t4_reissue_pc", bus.pc_out, 11'h000);
    check("t4_reissue_valid", bus.instr_valid, 1);
    check("t4_cnt_kept", bus.retired_cnt, 7);

    // Opcode decode and redirect alignment vectors, each from a fresh reset
    for (int v = 0; v < 14; v++) begin
      idle_inputs();
      rom[0] = vecs[v].word;
      do_reset();
      tick(2);
      check($sformatf("vec%0d_valid", v), bus.instr_valid, vecs[v].exp_valid);
      bus.redirect    = vecs[v].redir;
      bus.redirect_pc = vecs[v].rpc;
      tick(1);
      bus.redirect = 1'b0;
      check($sformatf("vec%0d_halt", v), bus.halt, vecs[v].exp_halt);
      check($sformatf("vec%0d_trap", v), bus.trap_misalign, vecs[v].exp_trap);
      check($sformatf("vec%0d_pc", v), bus.pc_out, vecs[v].exp_pc);
    end

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      rom[i][6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
    end
    idle_inputs();
    do_reset();
    m_pc = '0; m_wait = 2; m_halt = 0; m_trap = 0; m_cnt = '0;
    for (int c = 0; c < 2000; c++) begin
      check("rnd_valid", bus.instr_valid, (!m_halt && m_wait == 0));
      check("rnd_pc", bus.pc_out, m_pc);
      check("rnd_halt", bus.halt, m_halt);
      check("rnd_trap", bus.trap_misalign, m_trap);
      check("rnd_cnt", bus.retired_cnt, m_cnt);
      if (!m_halt && m_wait == 0) check("rnd_instr", bus.instr, rom[m_pc[9:2]]);
      bus.stall       = ($urandom_range(0, 2) == 0);
      bus.redirect    = ($urandom_range(0, 3) == 0);
      bus.resume      = ($urandom_range(0, 3) == 0);
      bus.redirect_pc = 11'($urandom);
      if ($urandom_range(0, 7) != 0) bus.redirect_pc[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) bus.redirect_pc = 11'h7FC;
      if (m_halt) begin
        if (bus.resume) begin
          m_halt = 0; m_trap = 0; m_pc = '0; m_wait = 2;
        end
      end else if (m_wait == 2) begin
        m_wait = 1;
      end else if (m_wait == 1) begin
        if (is_legal(rom[m_pc[9:2]][6:0])) m_wait = 0;
        else m_halt = 1;
      end else if (!bus.stall) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_wait = 2;
        if (bus.redirect) begin
          m_pc = bus.redirect_pc;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            m_halt = 1; m_trap = 1;
          end
        end else begin
          m_pc = m_pc + 11'd4;
        end
      end
      tick(1);
    end
    idle_inputs();

    // Narrow instance: PC wrap, counter saturation, async reset mid-ISSUE
    @(posedge clk);
    #1;
    rst6 = 1'b0;
    tick(2); check("t6_valid0", bus6.instr_valid, 1);
    check("t6_pc0", bus6.pc_out, 6'h00);
    bus6.redirect    = 1'b1;
    bus6.redirect_pc = 6'h3C;
    tick(1); check("t6_pc3c", bus6.pc_out, 6'h3C);
    bus6.redirect = 1'b0;
    tick(2); check("t6_valid3c", bus6.instr_valid, 1);
    check("t6_instr3c", bus6.instr, addi_word(15));
    tick(1); check("t6_wrap", bus6.pc_out, 6'h00);
    check("t6_cnt2", bus6.retired_cnt, 2);
    tick(2); check("t6_valid_wrap", bus6.instr_valid, 1);
    tick(60);
    check("t6_cnt_sat", bus6.retired_cnt, 4'hF);
    check("t6_valid_sat", bus6.instr_valid, 1);
    bus6.redirect    = 1'b1;
    bus6.redirect_pc = 6'h3C;
    tick(1);
    bus6.redirect = 1'b0;
    tick(2); check("t6_issue3c", bus6.pc_out, 6'h3C);
    #2;
    rst6 = 1'b1;
    #1;
    check("t6_arst_valid", bus6.instr_valid, 0);
    check("t6_arst_pc", bus6.pc_out, 6'h00);
    check("t6_arst_cnt", bus6.retired_cnt, 0);
    @(posedge clk);
    #1;
    rst6 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
